// File: rtl/if_stage_pkg.sv
// Shared pipeline constants: fetch defaults, RV32I opcode/funct encodings and
// the fetch FSM state type.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register. Flush beats stall beats load; when the decoder is
// free to consume and nothing new arrives, the slot drains to a NOP bubble.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic [31:0] load_inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  // The decoder consumes IF/ID every unstalled cycle, so no load means a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      inst_q  <= NOP_INST;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
    end else if (!stall_i) begin
      if (load_i) begin
        valid_q <= 1'b1;
        pc_q    <= load_pc_i;
        inst_q  <= load_inst_i;
      end else begin
        valid_q <= 1'b0;
        inst_q  <= NOP_INST;
      end
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one-outstanding fetch FSM, PC register and stale
// response dropping; feeds the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_inst,
  output logic [6:0]  ifid_op,
  output logic [2:0]  ifid_funct3,
  output logic [6:0]  ifid_funct7
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  buf_q, buf_d;
  logic         id_load;
  logic [31:0]  id_load_inst;
  logic [31:0]  pc_plus4;
  logic [31:0]  redir_target;

  assign pc_plus4     = pc_q + 32'd4;
  assign redir_target = align_word(redirect_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      buf_q   <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
    end
  end

  // A redirect always wins the PC; the drop flag marks a response already in
  // flight for the abandoned address so it is discarded when it lands.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    buf_d        = buf_q;
    id_load      = 1'b0;
    id_load_inst = imem_rdata;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        state_d = ST_WAIT;
        if (redirect_valid) begin
          pc_d   = redir_target;
          drop_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
          drop_d  = 1'b0;
          if (redirect_valid) begin
            pc_d = redir_target;
          end else if (!drop_q) begin
            if (stall) begin
              buf_d   = imem_rdata;
              state_d = ST_HOLD;
            end else begin
              id_load = 1'b1;
              pc_d    = pc_plus4;
            end
          end
        end else if (redirect_valid) begin
          pc_d   = redir_target;
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_target;
          state_d = ST_REQ;
        end else if (!stall) begin
          id_load      = 1'b1;
          id_load_inst = buf_q;
          pc_d         = pc_plus4;
          state_d      = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = pc_q;

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .stall_i    (stall),
    .load_i     (id_load),
    .load_pc_i  (pc_q),
    .load_inst_i(id_load_inst),
    .valid_o    (ifid_valid),
    .pc_o       (ifid_pc),
    .inst_o     (ifid_inst)
  );

  assign ifid_op     = ifid_inst[6:0];
  assign ifid_funct3 = ifid_inst[14:12];
  assign ifid_funct7 = ifid_inst[31:25];

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_inst;
  logic [6:0]  ifid_op;
  logic [2:0]  ifid_funct3;
  logic [6:0]  ifid_funct7;

  if_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_inst(ifid_inst),
    .ifid_op(ifid_op), .ifid_funct3(ifid_funct3), .ifid_funct7(ifid_funct7)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory: each request returns after its latency; image overrides a hash.
  typedef struct {
    logic [31:0] addr;
    int          lat;
  } memEntry_t;
  memEntry_t   memQ[$];
  logic [31:0] memImg[logic [31:0]];
  int fixLat = 1;
  bit randLat = 1'b0;
  bit memClearOnRst = 1'b1;
  bit spuriousEn = 1'b0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (memImg.exists(a)) return memImg[a];
    return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
  endfunction

  // Model: abstract fetch engine (just-reset / issuing / in flight / holding).
  bit          mStart, mIssue, mInFlight, mDiscard, mHeld, mIfValid;
  logic [31:0] mHeldInst, mPc, mIfPc, mIfInst;
  bit          ld;
  logic [31:0] ldPc, ldInst, tgt;
  bit          checkEn = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mStart = 1; mIssue = 0; mInFlight = 0; mDiscard = 0; mHeld = 0;
      mPc = RST_PC; mIfValid = 0; mIfPc = 32'h0; mIfInst = NOP;
    end else begin
      ld = 0; ldPc = mPc; ldInst = 32'h0;
      tgt = redirect_pc & 32'hFFFF_FFFC;
      if (mStart) begin
        mStart = 0; mIssue = 1;
      end else if (mIssue) begin
        mIssue = 0; mInFlight = 1;
        if (redirect_valid) begin mPc = tgt; mDiscard = 1; end
      end else if (mInFlight) begin
        if (imem_rvalid) begin
          mInFlight = 0; mIssue = 1;
          if (redirect_valid) mPc = tgt;
          else if (!mDiscard) begin
            if (stall) begin mHeld = 1; mHeldInst = imem_rdata; mIssue = 0; end
            else begin ld = 1; ldInst = imem_rdata; mPc = mPc + 32'd4; end
          end
          mDiscard = 0;
        end else if (redirect_valid) begin
          mPc = tgt; mDiscard = 1;
        end
      end else if (mHeld) begin
        if (redirect_valid) begin mHeld = 0; mIssue = 1; mPc = tgt; end
        else if (!stall) begin
          ld = 1; ldInst = mHeldInst; mPc = mPc + 32'd4; mHeld = 0; mIssue = 1;
        end
      end
      if (flush) begin mIfValid = 0; mIfInst = NOP; end
      else if (!stall) begin
        if (ld) begin mIfValid = 1; mIfPc = ldPc; mIfInst = ldInst; end
        else begin mIfValid = 0; mIfInst = NOP; end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("imem_req", {31'h0, imem_req}, {31'h0, mIssue});
      if (mIssue) checkOutput("imem_addr", imem_addr, mPc);
      checkOutput("ifid_valid", {31'h0, ifid_valid}, {31'h0, mIfValid});
      checkOutput("ifid_pc", ifid_pc, mIfPc);
      checkOutput("ifid_inst", ifid_inst, mIfInst);
      checkOutput("ifid_op", {25'h0, ifid_op}, {25'h0, mIfInst[6:0]});
      checkOutput("ifid_funct3", {29'h0, ifid_funct3}, {29'h0, mIfInst[14:12]});
      checkOutput("ifid_funct7", {25'h0, ifid_funct7}, {25'h0, mIfInst[31:25]});
    end
  end

  task automatic applyStimulus(input bit r, input bit st, input bit fl,
                               input bit rv, input logic [31:0] rpc);
    int lat;
    @(posedge clk); #1;
    rst = r; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
    if (r && memClearOnRst) memQ.delete();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    foreach (memQ[i]) memQ[i].lat--;
    if (memQ.size() > 0 && memQ[0].lat <= 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memData(memQ[0].addr);
      void'(memQ.pop_front());
    end else if (spuriousEn && memQ.size() == 0 && (mStart || mIssue) &&
                 $urandom_range(0, 3) == 0) begin
      imem_rvalid = 1'b1;
    end
    @(negedge clk);
    if (imem_req && !(rst && memClearOnRst)) begin
      lat = randLat ? int'($urandom_range(1, 3)) : fixLat;
      memQ.push_back('{imem_addr, lat});
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    memImg[32'h0]   = 32'h0050_0093;
    memImg[32'h4]   = 32'h00A0_0113;
    memImg[32'h100] = 32'h0010_0193;

    applyStimulus(1, 0, 0, 0, 0);
    checkEn = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_valid", {31'h0, ifid_valid}, 32'h0);
    checkOutput("rst_pc", ifid_pc, 32'h0);
    checkOutput("rst_inst", ifid_inst, NOP);
    checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_addr", imem_addr, RST_PC);

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("first_req", {31'h0, imem_req}, 32'h1);
    checkOutput("first_addr", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("first_valid", {31'h0, ifid_valid}, 32'h1);
    checkOutput("first_pc", ifid_pc, 32'h0);
    checkOutput("first_op", {25'h0, ifid_op}, 32'h13);
    checkOutput("next_addr", imem_addr, 32'h4);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, (i < 3), 0, 0, 0);
      checkOutput("stall_valid", {31'h0, ifid_valid}, 32'h1);
      checkOutput("stall_inst", ifid_inst, 32'h0050_0093);
      checkOutput("stall_pc", ifid_pc, 32'h0);
    end
    fixLat = 2;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("release_inst", ifid_inst, 32'h00A0_0113);
    checkOutput("release_pc", ifid_pc, 32'h4);
    checkOutput("release_addr", imem_addr, 32'h8);

    fixLat = 1;
    applyStimulus(0, 0, 0, 1, 32'h100);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("drop_noreq", {31'h0, imem_req}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("redir_req", {31'h0, imem_req}, 32'h1);
    checkOutput("redir_addr", imem_addr, 32'h100);
    checkOutput("stale_valid", {31'h0, ifid_valid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("stale_valid2", {31'h0, ifid_valid}, 32'h0);

    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("pre_flush_inst", ifid_inst, 32'h0010_0193);
    applyStimulus(0, 0, 0, 1, 32'h203);
    checkOutput("flush_valid", {31'h0, ifid_valid}, 32'h0);
    checkOutput("flush_inst", ifid_inst, 32'h0000_0013);
    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFE);
    checkOutput("align_addr", imem_addr, 32'h200);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 0);
    fixLat = 2;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("top_pc", ifid_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_addr", imem_addr, 32'h0);

    memClearOnRst = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("late_idle_valid", {31'h0, ifid_valid}, 32'h0);
    memClearOnRst = 1'b1;
    fixLat = 1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("late_req", {31'h0, imem_req}, 32'h1);
    checkOutput("late_addr", imem_addr, RST_PC);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("refetch_inst", ifid_inst, 32'h0050_0093);

    randLat = 1'b1;
    spuriousEn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0, rpc);
    end
    applyStimulus(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
